if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//  Instruction fetch queue between if_stage and the decode stage of the 32I core.
//  Buffers fetched {pc, pc4, inst} entries so fetch can run ahead while decode stalls.
//  Flushed on taken branch/jump redirect.
//  Presents a NOP bubble to decode whenever no valid entry is available.
// PARAMETERS
//  DEPTH   4    entries held; power of two, >= 2
//  XLEN    32   address/instruction width
// PORTS
//  clk        in   1     core clock; all state updates on rising edge
//  reset      in   1     asynchronous, active-high; clears all state
//  flush      in   1     redirect (pc_src or jump taken); discard all entries
//  in_valid   in   1     fetch entry valid this cycle
//  in_ready   out  1     queue can accept an entry
//  in_pc      in   XLEN  inst_addr from if_stage
//  in_pc4     in   XLEN  pc4 from if_stage
//  in_inst    in   XLEN  instruction word from imem
//  out_valid  out  1     head entry valid for decode
//  out_ready  in   1     decode consumes head this cycle
//  out_pc     out  XLEN  head pc
//  out_pc4    out  XLEN  head pc4
//  out_inst   out  XLEN  head instruction, or NOP_INST when !out_valid
//  count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (async assert): wr/rd pointers=0, count=0, out_valid=0, in_ready=1, out_pc=0, out_pc4=0,
//    out_inst=NOP_INST (32'h0000_0013). Storage contents are don't-care.
//  - Pointers: $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Low bits index storage
//    and wrap modulo DEPTH with no special case.
//  - in_ready = (count != DEPTH); it depends only on registered state, never on out_ready.
//  - push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
//  - Push and pop in the same cycle: both take effect and count is unchanged, including when count==1.
//  - Full (count==DEPTH): in_ready=0; in_valid is ignored, and fetch must hold its pc.
//  - Empty: out_valid=0; out_ready is ignored; data outputs are masked to 0/0/NOP_INST.
//  - flush: highest priority. Next cycle count=0 and out_valid=0. Any push or pop in the flush cycle
//    is discarded. The first post-flush entry is accepted the cycle after flush.
//  - Latency: one cycle from push to out_valid, because storage is registered and the head is read
//    from the array.
//  - Outputs are driven combinationally from the head entry and are stable while out_valid & ~out_ready.
//  - Reset asserted mid-operation: state clears immediately; there is no partial drain.
// CONFIGURATION
//  IF_ID_QUEUE_BYPASS_EN defined:
//    - When count==0, in_valid=1 and flush=0, the input entry is forwarded combinationally with
//      out_valid=1 in the same cycle (zero latency).
//    - If out_ready=1 in that cycle, the entry is consumed and not written; otherwise it is written.
//  Not defined: strict one-cycle latency; out_valid never depends combinationally on in_valid.
// STRUCTURE
//  Shared package if_pkg: XLEN, NOP_INST, fetch_entry_t {pc, pc4, inst}.
//  Sub-module if_id_queue_mem:
//    - DEPTH x fetch_entry_t register array.
//    - One synchronous write port, one asynchronous read port.
//    - No reset on storage.
//  Top holds pointers, count, flush/handshake control and output masking.
// TESTING
//  1. Reset release, no traffic -> in_ready=1, out_valid=0, out_inst=32'h00000013, count=0.
//  2. Push pc=0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; a fifth push at pc=0x10 is
//     dropped; drain order is 0x0,0x4,0x8,0xC.
//  3. Continuous push/pop at count=1 for 16 cycles -> count stays 1; pointers wrap and entries emerge
//     in order.
//  4. count=3, flush with simultaneous in_valid(pc=0x40) and out_ready -> next cycle count=0,
//     out_valid=0; pc=0x40 never appears.
//  5. Reset asserted mid-cycle with count=2 -> outputs go to reset values before the next clk edge.
//  6. BYPASS_EN, empty queue, push pc=0x100 with out_ready=1 -> out_valid=1 and out_pc=0x100 in the
//     same cycle; count remains 0.

Source files
------------

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the fetch -> decode path of the 32I core.
//   XLEN          : address / instruction width
//   NOP_INST      : bubble instruction (addi x0, x0, 0)
//   fetch_entry_t : one fetched entry {pc, pc4, inst}
//   bubble_entry(): entry presented to decode when nothing valid is available
// -----------------------------------------------------------------------------
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic fetch_entry_t bubble_entry();
    fetch_entry_t e;
    e.pc   = {XLEN{1'b0}};
    e.pc4  = {XLEN{1'b0}};
    e.inst = NOP_INST;
    return e;
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// -----------------------------------------------------------------------------
// if_id_queue_mem
// DEPTH x fetch_entry_t register array for the fetch queue. Storage has no
// reset; validity is tracked entirely by the pointers in the parent.
// Ports:
//   clk       : clock
//   i_wr_en   : write enable (synchronous write port)
//   i_wr_addr : write index
//   i_wr_data : entry to store
//   i_rd_addr : read index (asynchronous read port)
//   o_rd_data : entry at i_rd_addr
// -----------------------------------------------------------------------------
module if_id_queue_mem
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  fetch_entry_t i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output fetch_entry_t o_rd_data
);

  fetch_entry_t r_mem [DEPTH];

  // Synchronous write of one entry
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// Instruction fetch queue between if_stage and decode. Buffers {pc, pc4, inst}
// so fetch can run ahead while decode stalls; discarded on redirect (flush).
// Decode sees a NOP bubble (pc=0, pc4=0, inst=NOP_INST) whenever no valid
// entry is available.
// Optional feature: define IF_ID_QUEUE_BYPASS_EN to forward an input entry
// combinationally to decode when the queue is empty (zero latency).
// Ports:
//   clk, reset                  : clock, async active-high reset
//   flush                       : redirect, drop all entries (highest priority)
//   in_valid/in_ready           : fetch-side handshake
//   in_pc/in_pc4/in_inst        : fetched entry
//   out_valid/out_ready         : decode-side handshake
//   out_pc/out_pc4/out_inst     : head entry (masked to bubble when invalid)
//   count                       : occupied entries
// -----------------------------------------------------------------------------
module if_id_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pc4,
  input  logic [XLEN-1:0]          in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc4,
  output logic [XLEN-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic          w_empty;
  logic          w_full;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_rd_adv;
  fetch_entry_t  w_in_entry;
  fetch_entry_t  w_head;
  fetch_entry_t  w_out_entry;

  if_id_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_in_entry),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_head)
  );

  // Occupancy status, handshake qualification and head/bubble output selection
  always_comb begin
    w_in_entry.pc   = in_pc;
    w_in_entry.pc4  = in_pc4;
    w_in_entry.inst = in_inst;

    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
              (r_wr_ptr[AW] != r_rd_ptr[AW]);

    w_bypass = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    // Empty queue: hand the incoming entry straight to decode.
    w_bypass = w_empty & in_valid & ~flush;
`endif

    if (!w_empty) begin
      out_valid   = 1'b1;
      w_out_entry = w_head;
    end else if (w_bypass) begin
      out_valid   = 1'b1;
      w_out_entry = w_in_entry;
    end else begin
      out_valid   = 1'b0;
      w_out_entry = bubble_entry();
    end

    in_ready = ~w_full;
    w_push   = in_valid & ~w_full & ~flush;
    w_pop    = out_valid & out_ready & ~flush;

    // A bypassed entry consumed in the same cycle is never stored, and its
    // pop does not move the read pointer since nothing was queued.
    w_wr_en  = w_push & ~(w_bypass & out_ready);
    w_rd_adv = w_pop & ~w_bypass;

    out_pc   = w_out_entry.pc;
    out_pc4  = w_out_entry.pc4;
    out_inst = w_out_entry.inst;
    count    = r_wr_ptr - r_rd_ptr;
  end

  // Pointer update; flush restarts both pointers so the queue reads empty next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

endmodule
